// File: rtl/gelato_reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gelato_reg_bank_arbiter
// Description : Register-bank read arbiter between the operand collector and
//               the banked register file. Takes one snapshot of collector
//               entries, grants at most one read per bank with round-robin
//               priority across entries, reads the banks and returns one
//               response with the granted operands' data.
//               Optional macro GELATO_BANK_ARB_STATS_EN adds grant/conflict
//               counters (stat_grants, stat_conflicts).
// Revision    : 1.0 - initial release
// ============================================================================
module gelato_reg_bank_arbiter #(
  parameter int BANK_NUM       = 4,
  parameter int COLLECTOR_SIZE = 4,
  parameter int REG_W          = 5,
  parameter int DATA_W         = 32
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              req_valid,
  output logic                                              req_ready,
  input  logic [COLLECTOR_SIZE-1:0]                         req_entry_valid,
  input  logic [COLLECTOR_SIZE*3*REG_W-1:0]                 req_reg_num,
  input  logic [COLLECTOR_SIZE*3-1:0]                       req_reg_valid,
  output logic [BANK_NUM-1:0]                               bank_rd_en,
  output logic [BANK_NUM*(REG_W-$clog2(BANK_NUM))-1:0]      bank_rd_addr,
  input  logic [BANK_NUM*DATA_W-1:0]                        bank_rd_data,
  output logic                                              rsp_valid,
  input  logic                                              rsp_ready,
  output logic [BANK_NUM-1:0]                               rsp_data_valid,
  output logic [BANK_NUM*$clog2(COLLECTOR_SIZE)-1:0]        rsp_collector_index,
  output logic [BANK_NUM*2-1:0]                             rsp_reg_index,
  output logic [BANK_NUM*DATA_W-1:0]                        rsp_data
`ifdef GELATO_BANK_ARB_STATS_EN
  ,
  output logic [31:0]                                       stat_grants,
  output logic [31:0]                                       stat_conflicts
`endif
);

  localparam int BANK_W = $clog2(BANK_NUM);
  localparam int ROW_W  = REG_W - BANK_W;
  localparam int CIDX_W = $clog2(COLLECTOR_SIZE);
  localparam int NSLOT  = COLLECTOR_SIZE * 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_READ = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       w_accept;

  logic [COLLECTOR_SIZE-1:0]  r_entry_valid;
  logic [NSLOT*REG_W-1:0]     r_reg_num;
  logic [NSLOT-1:0]           r_reg_valid;
  logic [CIDX_W-1:0]          r_rr_ptr;
  logic [BANK_NUM-1:0]        r_grant;

  logic [NSLOT-1:0]           w_elig;
  logic [BANK_NUM-1:0]        w_grant;
  logic [CIDX_W-1:0]          w_win_k   [BANK_NUM];
  logic [1:0]                 w_win_j   [BANK_NUM];
  logic [ROW_W-1:0]           w_win_row [BANK_NUM];

  // Slot index of priority position p; entry offset wraps via CIDX_W arithmetic.
  function automatic int slot_of(input logic [CIDX_W-1:0] ptr, input int p);
    logic [CIDX_W-1:0] k;
    k = ptr + CIDX_W'(p / 3);
    return int'(k) * 3 + (p % 3);
  endfunction

  // Operand eligibility from the registered snapshot.
  always_comb begin
    w_elig = '0;
    for (int s = 0; s < NSLOT; s++) begin
      w_elig[s] = r_entry_valid[s / 3] & r_reg_valid[s];
    end
  end

  // Per-bank winner: scan from lowest to highest priority so the last hit wins.
  always_comb begin
    w_grant = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      w_win_k[b]   = '0;
      w_win_j[b]   = 2'd0;
      w_win_row[b] = '0;
    end
    for (int p = NSLOT - 1; p >= 0; p--) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        if (w_elig[slot_of(r_rr_ptr, p)] &&
            (r_reg_num[slot_of(r_rr_ptr, p)*REG_W +: BANK_W] == BANK_W'(b))) begin
          w_grant[b]   = 1'b1;
          w_win_k[b]   = r_rr_ptr + CIDX_W'(p / 3);
          w_win_j[b]   = 2'((p % 3) + 1);
          w_win_row[b] = r_reg_num[slot_of(r_rr_ptr, p)*REG_W + BANK_W +: ROW_W];
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_ARB;
        end
      end
      S_ARB:   w_state_next = (|w_grant) ? S_READ : S_RESP;
      S_READ:  w_state_next = S_RESP;
      S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Snapshot capture, grant registration, bank read and response datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry_valid       <= '0;
      r_reg_num           <= '0;
      r_reg_valid         <= '0;
      r_rr_ptr            <= '0;
      r_grant             <= '0;
      bank_rd_en          <= '0;
      bank_rd_addr        <= '0;
      rsp_valid           <= 1'b0;
      rsp_data_valid      <= '0;
      rsp_collector_index <= '0;
      rsp_reg_index       <= '0;
      rsp_data            <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_entry_valid <= req_entry_valid;
            r_reg_num     <= req_reg_num;
            r_reg_valid   <= req_reg_valid;
          end
        end
        S_ARB: begin
          r_grant    <= w_grant;
          bank_rd_en <= w_grant;
          for (int b = 0; b < BANK_NUM; b++) begin
            bank_rd_addr[b*ROW_W +: ROW_W]         <= w_win_row[b];
            rsp_collector_index[b*CIDX_W +: CIDX_W] <= w_win_k[b];
            rsp_reg_index[b*2 +: 2]                 <= w_win_j[b];
          end
          // Nothing eligible: answer immediately with an all-invalid response.
          if (!(|w_grant)) begin
            rsp_valid      <= 1'b1;
            rsp_data_valid <= '0;
          end
        end
        S_READ: begin
          bank_rd_en     <= '0;
          rsp_valid      <= 1'b1;
          rsp_data_valid <= r_grant;
          for (int b = 0; b < BANK_NUM; b++) begin
            if (r_grant[b]) begin
              rsp_data[b*DATA_W +: DATA_W] <= bank_rd_data[b*DATA_W +: DATA_W];
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (|r_grant) begin
              r_rr_ptr <= r_rr_ptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GELATO_BANK_ARB_STATS_EN
  logic [31:0] w_n_grant;
  logic [31:0] w_n_elig;

  // Population counts of granted and eligible operands for this round.
  always_comb begin
    w_n_grant = '0;
    w_n_elig  = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      w_n_grant = w_n_grant + 32'(w_grant[b]);
    end
    for (int s = 0; s < NSLOT; s++) begin
      w_n_elig = w_n_elig + 32'(w_elig[s]);
    end
  end

  // Wrapping grant/conflict counters, updated once per arbitration round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else if (r_state == S_ARB) begin
      stat_grants    <= stat_grants + w_n_grant;
      stat_conflicts <= stat_conflicts + (w_n_elig - w_n_grant);
    end
  end
`endif

endmodule
`default_nettype wire
